sram_bus_master: RTL and testbench
==================================

// Module: sram_bus_master
// PURPOSE
//  Initiator for the single-port RAM shared-bus interface (we/oe/addr, bidirectional data).
//  Accepts burst read/write commands on valid/ready handshakes and sequences the RAM pins.
//  Owns the tristate data driver and guarantees we/oe are never both asserted.
//  Sits between a client engine (DMA, test sequencer) and one single-port RAM instance.
// PARAMETERS
//  ADDR_W  4  RAM address width; burst addresses wrap modulo 2**ADDR_W
//  DATA_W  8  RAM data width
//  RD_LAT  1  cycles from mem_oe/mem_addr registered to valid mem_data (>=1)
// PORTS
//  clk         in     1       clock, all logic on posedge
//  reset       in     1       synchronous, active-high
//  req_valid   in     1       command valid
//  req_ready   out    1       command accept; high only in IDLE
//  req_write   in     1       1 = write burst, 0 = read burst
//  req_addr    in     ADDR_W  burst start address
//  req_len     in     ADDR_W  beats minus one (0 = 1 beat, max 2**ADDR_W beats)
//  wdata       in     DATA_W  write beat data
//  wvalid      in     1       write beat valid
//  wready      out    1       write beat accept
//  rdata       out    DATA_W  read beat data (registered)
//  rvalid      out    1       read beat valid
//  rlast       out    1       final beat of burst, qualified by rvalid
//  rready      in     1       read beat accept
//  busy        out    1       command in progress (state != IDLE)
//  mem_we      out    1       RAM write enable
//  mem_oe      out    1       RAM output enable
//  mem_addr    out    ADDR_W  RAM address
//  mem_data    inout  DATA_W  RAM data; driven only when mem_we=1, else high-Z
// BEHAVIOUR
//  Reset: req_ready=0, wready=0, rvalid=0, rlast=0, busy=0, mem_we=0, mem_oe=0,
//   mem_addr=0, rdata=0, mem_data high-Z; state IDLE. req_ready=1 the cycle after reset drops.
//  Reset mid-burst: burst abandoned, all outputs to reset values at that edge, no further beats.
//  FSM: IDLE, WR, WR_END, RD_ISSUE, RD_WAIT, RD_HOLD. All pin outputs registered.
//  IDLE: req_ready=1, mem_we=mem_oe=0 (acts as mandatory bus-turnaround cycle).
//   req_valid&&req_ready at edge: latch addr->cur, len->cnt; goto WR or RD_ISSUE.
//  WR: wready=1. Beat accepted at edge N -> during cycle N+1 mem_we=1, mem_addr=cur,
//   mem_data=wdata; RAM captures at edge N+1. cur++ (wrap), cnt--.
//   wvalid=0 at edge -> mem_we=0 next cycle (bubble, no write). Last beat (cnt==0) -> WR_END.
//  WR_END: one cycle, last write completes on the bus; wready=0; next edge mem_we=0, -> IDLE.
//  RD_ISSUE: register mem_oe=1, mem_addr=cur; -> RD_WAIT with counter RD_LAT.
//  RD_WAIT: after RD_LAT cycles sample mem_data into rdata, rvalid=1, rlast=(cnt==0); -> RD_HOLD.
//  RD_HOLD: rdata/rvalid/rlast stable until rready. mem_oe, mem_addr held throughout.
//   On rvalid&&rready: rvalid=0; if rlast -> mem_oe=0, IDLE; else cur++, cnt--, RD_ISSUE.
//  Read beat minimum period RD_LAT+2 cycles; no read pipelining.
//  Invariants: never mem_we&&mem_oe; mem_data released same cycle mem_we falls;
//   a write->read or read->write switch always has >=1 cycle with both enables low.
//  req_* sampled only on accept; changes while busy ignored. wvalid in read burst ignored.
//  rready while rvalid=0 ignored. Address wrap: 4'hF + 1 -> 4'h0 with no gap.
// TESTING
//  1. Reset, single write addr=3 data=8'hA5, then single read addr=3 -> rdata=8'hA5, rlast=1.
//  2. Write burst addr=0 len=15 data=i*3, read back len=15 -> 16 beats match, rlast on beat 16 only.
//  3. Write burst addr=14 len=3 -> RAM[14,15,0,1] written; RAM[2] unchanged (wrap check).
//  4. wvalid toggled every other cycle mid-write; rready held low 5 cycles mid-read ->
//     no mem_we on bubbles, rdata/mem_addr/mem_oe stable during stall, data intact.
//  5. reset asserted during beat 2 of 8-beat write -> mem_we=0, mem_data Z next cycle,
//     beats 3..8 never written; req_ready=1 after release.
//  6. Back-to-back write then read command -> >=1 cycle with mem_we=mem_oe=0 between;
//     assertion checker: never mem_we&&mem_oe, no X on mem_data when mem_we=1.

Source files
------------

// File: rtl/sram_bus_master.sv
// sram_bus_master: burst read/write initiator for a single-port RAM bus (clk/reset, req_*, w*, r*, busy, mem_we/oe/addr, tristate mem_data).
module sram_bus_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rlast,
  input  logic              rready,
  output logic              busy,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);
  localparam int LW = $clog2(RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, WR, WR_END, RD_ISSUE, RD_WAIT, RD_HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, cnt_q, cnt_d, addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DATA_W-1:0] wd_q, wd_d, rdata_q, rdata_d;
  logic we_q, we_d, oe_q, oe_d, rvalid_q, rvalid_d, rlast_q, rlast_d, rdy_q, wrdy_q;
  assign req_ready = rdy_q;
  assign wready    = wrdy_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign busy      = state_q != IDLE;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
  assign mem_addr  = addr_q;
  assign mem_data  = we_q ? wd_q : {DATA_W{1'bz}};
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    we_d     = 1'b0;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    case (state_q)
      IDLE: if (req_valid && rdy_q) begin
        cur_d   = req_addr;
        cnt_d   = req_len;
        state_d = req_write ? WR : RD_ISSUE;
      end
      WR: if (wvalid) begin
        we_d    = 1'b1;
        addr_d  = cur_q;
        wd_d    = wdata;
        cur_d   = cur_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? WR_END : WR;
      end
      WR_END: state_d = IDLE;
      RD_ISSUE: begin
        oe_d    = 1'b1;
        addr_d  = cur_q;
        lat_d   = LW'(RD_LAT);
        state_d = RD_WAIT;
      end
      RD_WAIT: if (lat_q == LW'(1)) begin
        rdata_d  = mem_data;
        rvalid_d = 1'b1;
        rlast_d  = cnt_q == '0;
        state_d  = RD_HOLD;
      end else begin
        lat_d = lat_q - 1'b1;
      end
      RD_HOLD: if (rready) begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        oe_d     = !rlast_q;
        cur_d    = rlast_q ? cur_q : cur_q + 1'b1;
        cnt_d    = rlast_q ? cnt_q : cnt_q - 1'b1;
        state_d  = rlast_q ? IDLE : RD_ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdy_q    <= 1'b0;
      wrdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdy_q    <= state_d == IDLE;
      wrdy_q   <= state_d == WR;
    end
  end
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: directed, table-driven checks of sram_bus_master against a behavioural RAM.
module tb_sram_bus_master;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, wvalid = 1'b0, rready = 1'b0;
  logic [3:0] req_addr = '0, req_len = '0;
  logic [7:0] wdata = '0;
  logic req_ready, wready, rvalid, rlast, busy, mem_we, mem_oe;
  logic [7:0] rdata;
  logic [3:0] mem_addr;
  wire  [7:0] mem_data;
  logic [7:0] ram [16];
  logic pw = 1'b0, po = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sram_bus_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .rdata(rdata),
    .rvalid(rvalid), .rlast(rlast), .rready(rready), .busy(busy),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  assign mem_data = (mem_oe && !mem_we) ? ram[mem_addr] : 8'bz;
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we || mem_oe) begin
      n_chk++;
      if ((mem_we && mem_oe) || (mem_we && po) || (mem_oe && pw)) begin
        n_fail++;
        $display("FAIL bus_turnaround: we=%0b oe=%0b prev_we=%0b prev_oe=%0b at %0t", mem_we, mem_oe, pw, po, $time);
      end
    end
    if (mem_we) assert (!$isunknown(mem_data));
    pw <= mem_we;
    po <= mem_oe;
  end

  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wr_burst(input logic [3:0] a, input logic [3:0] l, input logic [7:0] d0, input logic [7:0] st, input logic gap);
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (gap && i > 0) begin
        wvalid = 1'b0;
        @(negedge clk);
        check("bubble_no_we", mem_we, 0);
      end
      check("wready", wready, 1);
      wdata  = d0 + 8'(i) * st;
      wvalid = 1'b1;
      @(negedge clk);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, 4'(a + 4'(i)));
      check("wr_data", mem_data, d0 + 8'(i) * st);
    end
    wvalid = 1'b0;
  endtask

  task automatic rd_burst(input logic [3:0] a, input logic [3:0] l, input logic [7:0] d0, input logic [7:0] st, input logic stall);
    send_cmd(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      int t = 0;
      while (!rvalid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("rvalid", rvalid, 1);
      check("rdata", rdata, d0 + 8'(i) * st);
      check("rlast", rlast, i == int'(l));
      check("rd_oe", mem_oe, 1);
      check("rd_addr", mem_addr, 4'(a + 4'(i)));
      if (stall && i == 1) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, d0 + 8'(i) * st);
          check("stall_addr", mem_addr, 4'(a + 4'(i)));
          check("stall_oe", mem_oe, 1);
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rvalid_drop", rvalid, 0);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] d0;
    logic [7:0] step;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  4'd0,  8'hA5, 8'd0};
    vecs[1] = '{1'b0, 4'd3,  4'd0,  8'hA5, 8'd0};
    vecs[2] = '{1'b1, 4'd0,  4'd15, 8'h00, 8'd3};
    vecs[3] = '{1'b0, 4'd0,  4'd15, 8'h00, 8'd3};
    vecs[4] = '{1'b1, 4'd14, 4'd3,  8'h80, 8'd1};
    vecs[5] = '{1'b0, 4'd14, 4'd3,  8'h80, 8'd1};
    vecs[6] = '{1'b0, 4'd2,  4'd0,  8'h06, 8'd0};
    vecs[7] = '{1'b0, 4'd4,  4'd1,  8'h0C, 8'd3};

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) wr_burst(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].step, 1'b0);
      else rd_burst(vecs[v].addr, vecs[v].len, vecs[v].d0, vecs[v].step, 1'b0);
    end

    wr_burst(4'd12, 4'd3, 8'h50, 8'd1, 1'b1);
    rd_burst(4'd12, 4'd3, 8'h50, 8'd1, 1'b1);

    send_cmd(1'b1, 4'd4, 4'd7);
    wdata  = 8'hC0;
    wvalid = 1'b1;
    @(negedge clk);
    wdata = 8'hC1;
    @(negedge clk);
    check("beat2_addr", mem_addr, 5);
    check("beat2_we", mem_we, 1);
    wdata = 8'hC2;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_we", mem_we, 0);
    check("midrst_wready", wready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_oe", mem_oe, 0);
    wdata = 8'hC3;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    check("ready_after_midrst", req_ready, 1);
    repeat (3) @(negedge clk);
    check("midrst_ram4", ram[4], 8'hC0);
    check("midrst_ram5", ram[5], 8'hC1);
    for (int i = 6; i < 12; i++) check("midrst_untouched", ram[i], 8'(i * 3));
    rd_burst(4'd6, 4'd5, 8'd18, 8'd3, 1'b0);

    wr_burst(4'd0, 4'd0, 8'h77, 8'd0, 1'b0);
    rd_burst(4'd0, 4'd0, 8'h77, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
